// File: rtl/ov5640_stream_capture_pkg.sv
// Shared types for the OV5640 DVP capture: capture modes, FSM encoding, pixel layout
// and the format expander that widens every mode to 8 bit per channel.
package ov5640_pkg;

  typedef enum logic [1:0] {
    MODE_RGB565 = 2'd0,
    MODE_YUV422 = 2'd1,
    MODE_RAW8   = 2'd2,
    MODE_RSVD   = 2'd3
  } capture_mode_e;

  typedef logic [1:0] state_t;
  localparam logic [1:0] ST_WAIT_VS = 2'd0;
  localparam logic [1:0] ST_BLANK   = 2'd1;
  localparam logic [1:0] ST_ACTIVE  = 2'd2;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } pixel_t;

  // FIFO entry: {tuser, tlast, rgb}
  localparam int FIFO_W = 26;

  // hi is the first byte of a two-byte pixel; one-byte modes use lo only.
  // YUV422 arrives as Y first, so hi carries luma.
  function automatic pixel_t expand_pixel(input capture_mode_e m, input logic [7:0] hi,
                                          input logic [7:0] lo);
    pixel_t px;
    case (m)
      MODE_RGB565: begin
        px.r = {hi[7:3], hi[7:5]};
        px.g = {hi[2:0], lo[7:5], hi[2:1]};
        px.b = {lo[4:0], lo[4:2]};
      end
      MODE_YUV422: begin
        px.r = hi;
        px.g = hi;
        px.b = hi;
      end
      default: begin
        px.r = lo;
        px.g = lo;
        px.b = lo;
      end
    endcase
    return px;
  endfunction

endpackage

// File: rtl/ov5640_stream_capture_fifo.sv
// Synchronous pixel FIFO with a registered read stage; the output register counts as
// one of the DEPTH entries, so "full" means DEPTH beats are held in total.
module axis_pixel_fifo #(
  parameter int WIDTH = 26,
  parameter int DEPTH = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             wr_ready,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  input  logic             rd_ready
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic [AW:0]      mem_count;
  logic             pop;
  logic             push;
  logic             load;

  // A pop in the same cycle frees a slot, so a write to a full FIFO is still accepted.
  assign pop       = rd_valid & rd_ready;
  assign wr_ready  = (count != FULL_CNT) | pop;
  assign push      = wr_en & wr_ready;
  assign mem_count = count - (AW + 1)'(rd_valid);
  assign load      = (mem_count != '0) & (~rd_valid | pop);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (load) begin
        rd_data <= mem[rd_ptr];
        rd_ptr  <= rd_ptr + 1'b1;
      end
      rd_valid <= load | (rd_valid & ~pop);
      count    <= count + (AW + 1)'(push) - (AW + 1)'(pop);
    end
  end

endmodule

// File: rtl/ov5640_stream_capture.sv
// OV5640 DVP capture to AXI4-Stream: frame FSM, byte-pair assembly, format expansion,
// one-deep hold register for tlast tagging, geometry checks and sticky status flags.
module ov5640_stream_capture
  import ov5640_pkg::*;
#(
  parameter int TDATA_W    = 32,
  parameter int FIFO_DEPTH = 1024,
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int VSYNC_POL  = 1
) (
  input  logic                 pclk,
  input  logic                 reset_n,
  input  logic                 vsync,
  input  logic                 href,
  input  logic [7:0]           d,
  input  logic [1:0]           mode,
  output logic [TDATA_W-1:0]   m_tdata,
  output logic                 m_tvalid,
  input  logic                 m_tready,
  output logic                 m_tuser,
  output logic                 m_tlast,
  output logic [TDATA_W/8-1:0] m_tkeep,
  output logic                 frame_done,
  output logic                 overflow,
  output logic                 geom_err,
  input  logic                 clr_status
);

  // Reset vsync to its non-blanking level so a reset never fakes a frame boundary.
  localparam logic VS_IDLE = (VSYNC_POL != 0) ? 1'b0 : 1'b1;

  logic          vs_r;
  logic          href_r;
  logic [7:0]    d_r;
  state_t        state;
  capture_mode_e mode_reg;
  logic          phase;
  logic [7:0]    hi_byte;
  pixel_t        hold;
  logic          hold_valid;
  logic          line_open;
  logic          sof_pending;
  logic          drop;
  logic [15:0]   pix_cnt;
  logic [15:0]   line_cnt;

  logic              blank;
  logic              in_active;
  logic              two_byte;
  logic              capture;
  logic              pix_done;
  logic              close_line;
  logic              hold_write;
  logic              fifo_wr;
  logic              fifo_wr_ready;
  logic              overflow_set;
  logic              sof_start;
  logic              frame_end;
  logic              line_bad;
  logic              frame_bad;
  logic [15:0]       line_cnt_final;
  pixel_t            new_px;
  logic [FIFO_W-1:0] fifo_wr_data;
  logic [FIFO_W-1:0] fifo_rd_data;

  assign blank     = (VSYNC_POL != 0) ? vs_r : ~vs_r;
  assign in_active = (state == ST_ACTIVE);
  assign two_byte  = (mode_reg == MODE_RGB565) | (mode_reg == MODE_YUV422);
  assign capture   = in_active & ~blank & href_r;
  assign pix_done  = capture & (~two_byte | phase);
  assign new_px    = expand_pixel(mode_reg, hi_byte, d_r);

  // A line ends on href falling, or early when vsync enters blanking mid-line.
  assign close_line     = in_active & line_open & (~href_r | blank);
  assign hold_write     = (pix_done | close_line) & hold_valid;
  assign fifo_wr        = hold_write & ~drop;
  assign fifo_wr_data   = {sof_pending, close_line, hold};
  assign overflow_set   = fifo_wr & ~fifo_wr_ready;
  assign sof_start      = (state == ST_BLANK) & ~blank;
  assign frame_end      = in_active & blank;
  assign line_cnt_final = line_cnt + 16'(close_line);
  assign line_bad       = close_line & ((pix_cnt != 16'(H_ACTIVE)) | phase);
  assign frame_bad      = frame_end & (line_cnt_final != 16'(V_ACTIVE));

  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      vs_r   <= VS_IDLE;
      href_r <= 1'b0;
      d_r    <= '0;
    end else begin
      vs_r   <= vsync;
      href_r <= href;
      d_r    <= d;
    end
  end

  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_WAIT_VS;
    end else begin
      case (state)
        ST_WAIT_VS: if (blank) state <= ST_BLANK;
        ST_BLANK:   if (!blank) state <= ST_ACTIVE;
        ST_ACTIVE:  if (blank) state <= ST_BLANK;
        default:    state <= ST_WAIT_VS;
      endcase
    end
  end

  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      mode_reg    <= MODE_RGB565;
      phase       <= 1'b0;
      hi_byte     <= '0;
      hold        <= '0;
      hold_valid  <= 1'b0;
      line_open   <= 1'b0;
      sof_pending <= 1'b0;
      drop        <= 1'b0;
      pix_cnt     <= '0;
      line_cnt    <= '0;
    end else begin
      if (sof_start) begin
        mode_reg <= capture_mode_e'(mode);
      end
      if (close_line) begin
        phase     <= 1'b0;
        line_open <= 1'b0;
        pix_cnt   <= '0;
      end else begin
        if (capture) begin
          line_open <= 1'b1;
        end
        if (capture & two_byte) begin
          phase <= ~phase;
        end
        if (capture & two_byte & ~phase) begin
          hi_byte <= d_r;
        end
        if (pix_done) begin
          pix_cnt <= pix_cnt + 16'd1;
        end
      end
      if (pix_done) begin
        hold       <= new_px;
        hold_valid <= 1'b1;
      end else if (close_line) begin
        hold_valid <= 1'b0;
      end
      // After an overflow, everything is dropped until the next SOF re-arms tuser.
      if (sof_start) begin
        sof_pending <= 1'b1;
        drop        <= 1'b0;
        line_cnt    <= '0;
      end else begin
        if (fifo_wr & fifo_wr_ready) begin
          sof_pending <= 1'b0;
        end
        if (overflow_set) begin
          drop <= 1'b1;
        end
        if (close_line) begin
          line_cnt <= line_cnt + 16'd1;
        end
      end
    end
  end

  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      frame_done <= 1'b0;
      overflow   <= 1'b0;
      geom_err   <= 1'b0;
    end else begin
      frame_done <= frame_end;
      overflow   <= clr_status ? 1'b0 : (overflow | overflow_set);
      geom_err   <= clr_status ? 1'b0 : (geom_err | line_bad | frame_bad);
    end
  end

  axis_pixel_fifo #(
    .WIDTH(FIFO_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk     (pclk),
    .rst_n   (reset_n),
    .wr_en   (fifo_wr),
    .wr_data (fifo_wr_data),
    .wr_ready(fifo_wr_ready),
    .rd_data (fifo_rd_data),
    .rd_valid(m_tvalid),
    .rd_ready(m_tready)
  );

  assign m_tuser = fifo_rd_data[25];
  assign m_tlast = fifo_rd_data[24];
  assign m_tdata = TDATA_W'(fifo_rd_data[23:0]);
  assign m_tkeep = '1;

endmodule
